// File: rtl/display_pkg.sv
// Shared types and helpers for the scanned seven-segment display blocks.
package display_pkg;
  localparam int BCD_W      = 4;
  localparam int DIGITS_MAX = 8;
  localparam int IDX_W      = $clog2(DIGITS_MAX);

  localparam logic [DIGITS_MAX-1:0] ANODE_OFF = '1;

  typedef logic [IDX_W-1:0]                   digit_idx_t;
  typedef logic [DIGITS_MAX-1:0][BCD_W-1:0]   digit_vec_t;
  typedef enum logic { ST_BLANK, ST_DRIVE }   scan_state_t;

  // Bit i set when digits n-1..i are all zero; digit 0 always stays visible.
  function automatic logic [DIGITS_MAX-1:0] lzb_mask(input digit_vec_t digits, input int n);
    logic nz;
    lzb_mask = '0;
    nz       = 1'b0;
    for (int i = DIGITS_MAX-1; i >= 1; i--) begin
      if (i < n) begin
        nz          = nz | (digits[i] != '0);
        lzb_mask[i] = ~nz;
      end
    end
  endfunction
endpackage

// File: rtl/display_scan_mux_if.sv
// Digit input / scan output bundle between the display counter and the mux.
interface display_scan_mux_if #(parameter int DIGITS = 4);
  import display_pkg::*;

  logic                      Enable;
  logic                      LzbEn;
  logic [BCD_W*DIGITS-1:0]   Digits;
  logic [BCD_W-1:0]          BCD;
  logic [DIGITS-1:0]         Anodes;
  logic                      FrameStart;

  modport master (output Enable, LzbEn, Digits, input  BCD, Anodes, FrameStart);
  modport slave  (input  Enable, LzbEn, Digits, output BCD, Anodes, FrameStart);
endinterface

// File: rtl/scan_tick_gen.sv
// Slot prescaler for scanned displays: counts 0..SCAN_DIV-1, flags the wrap
// and whether the slot is still inside its blanking window.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter  int SCAN_DIV     = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int CNT_W        = $clog2(SCAN_DIV)
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             slot_wrap,
  output logic             blank
);
  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // State is decoded from the next count so it stays aligned with slot_cnt.
  always_comb begin
    slot_wrap = 1'b0;
    cnt_nxt   = slot_cnt;
    state_nxt = state;
    slot_wrap = (slot_cnt == CNT_W'(SCAN_DIV-1));
    cnt_nxt   = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
    state_nxt = (cnt_nxt < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      slot_cnt <= '0;
      state    <= ST_BLANK;
    end else begin
      slot_cnt <= cnt_nxt;
      state    <= state_nxt;
    end
  end

  assign blank = (state == ST_BLANK);
endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner: per-frame digit snapshot, registered BCD out,
// and anode enables delayed to line up with the registered segment converter.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                Clk,
  input  logic                Rst,
  display_scan_mux_if.slave   bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0]          slot_cnt;
  logic                      slot_wrap, blank;
  digit_idx_t                idx;
  logic [BCD_W*DIGITS-1:0]   shadow, cur;
  digit_vec_t                cur_x;
  logic [DIGITS_MAX-1:0]     lzb, an_raw_x;
  logic [DIGITS-1:0]         an_raw, an_d1, anodes_q;
  logic [BCD_W-1:0]          bcd_q;
  logic                      frame_start, lit;

  scan_tick_gen #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .Clk       (Clk),
    .Rst       (Rst),
    .slot_cnt  (slot_cnt),
    .slot_wrap (slot_wrap),
    .blank     (blank)
  );

  // On the latch cycle the incoming Digits are used directly, so digit 0 of a
  // new frame already reflects the captured value.
  always_comb begin
    frame_start = ~Rst & (slot_cnt == '0) & (idx == '0);
    cur         = frame_start ? bus.Digits : shadow;
    cur_x       = '0;
    for (int i = 0; i < DIGITS; i++) cur_x[i] = cur[i*BCD_W +: BCD_W];
    lzb         = bus.LzbEn ? lzb_mask(cur_x, DIGITS) : '0;
    lit         = bus.Enable & ~blank & ~lzb[idx];
    an_raw_x    = ANODE_OFF;
    if (lit) an_raw_x[idx] = 1'b0;
    an_raw      = an_raw_x[DIGITS-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx      <= '0;
      shadow   <= '0;
      bcd_q    <= '0;
      an_d1    <= ANODE_OFF[DIGITS-1:0];
      anodes_q <= ANODE_OFF[DIGITS-1:0];
    end else begin
      if (slot_wrap) idx <= (idx == digit_idx_t'(DIGITS-1)) ? '0 : idx + digit_idx_t'(1);
      if (frame_start) shadow <= bus.Digits;
      bcd_q    <= cur_x[idx];
      an_d1    <= an_raw;
      anodes_q <= an_d1;
    end
  end

  assign bus.BCD        = bcd_q;
  assign bus.Anodes     = anodes_q;
  assign bus.FrameStart = frame_start;
endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized bench for display_scan_mux against a cycle-count based scan model.
module tb_display_scan_mux;
  import display_pkg::*;

  localparam int D = 4, S = 8, B = 2, F = D*S;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  display_scan_mux_if #(.DIGITS(D)) bus();

  display_scan_mux #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_vec = 0, n_err = 0;

  // Model: k = cycles since reset release; slot/index follow by division.
  int             k;
  logic           m_valid;
  logic [4*D-1:0] m_shadow;
  logic [3:0]     m_bcd;
  logic [D-1:0]   m_an[$];
  logic [D-1:0]   off_v = '1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  function automatic logic [D-1:0] anode_for(input int cnt, input int idx, input logic en,
                                              input logic lzb, input logic [4*D-1:0] v);
    logic blanked;
    blanked = 1'b0;
    if (lzb && idx > 0) blanked = ((v >> (4*idx)) == '0);
    if (cnt < B || !en || blanked) return '1;
    return ~(D'(1) << idx);
  endfunction

  task automatic cycle();
    logic           fs_exp;
    logic [4*D-1:0] cur;
    int             cnt, idx;
    @(negedge Clk);
    cnt    = k % S;
    idx    = (k / S) % D;
    fs_exp = !Rst && cnt == 0 && idx == 0;
    if (m_valid) begin
      chk("bcd",         32'(bus.BCD),        32'(m_bcd));
      chk("anodes",      32'(bus.Anodes),     32'(m_an[0]));
      chk("frame_start", 32'(bus.FrameStart), 32'(fs_exp));
    end
    if (Rst) begin
      k        = 0;
      m_shadow = '0;
      m_bcd    = '0;
      m_an     = {off_v, off_v};
      m_valid  = 1'b1;
    end else begin
      cur      = fs_exp ? bus.Digits : m_shadow;
      m_shadow = cur;
      m_bcd    = cur[4*idx +: 4];
      void'(m_an.pop_front());
      m_an.push_back(anode_for(cnt, idx, bus.Enable, bus.LzbEn, cur));
      k++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model sits at the given position within the frame.
  task automatic run_to(input int phase);
    for (int i = 0; i < F && (k % F) != phase; i++) cycle();
  endtask

  initial begin
    Rst        = 1'b1;
    bus.Enable = 1'b1;
    bus.LzbEn  = 1'b0;
    bus.Digits = 16'h1234;
    k          = 0;
    m_valid    = 1'b0;
    m_shadow   = '0;
    m_bcd      = '0;
    m_an       = {off_v, off_v};
    #1;
    run(3);
    Rst = 1'b0;
    run(2*F);

    bus.Digits = 16'h0056; bus.LzbEn = 1'b1;
    run_to(0); run(2*F);
    bus.Digits = 16'h0000;
    run_to(0); run(2*F);

    bus.LzbEn = 1'b0; bus.Digits = 16'h1234;
    run_to(0); run_to(S + 3);
    bus.Digits = 16'h9999;
    run(2*F);

    run_to(5);
    bus.Enable = 1'b0; run(20);
    bus.Enable = 1'b1; run(F);

    bus.Digits = 16'h1234;
    run_to(0); run_to(2*S + 5);
    Rst = 1'b1; cycle();
    Rst = 1'b0; run(F + 4);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0)  bus.Digits = 16'($urandom) >> (4*$urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0)  bus.Enable = ~bus.Enable;
      if ($urandom_range(0, 49) == 0)  bus.LzbEn  = ~bus.LzbEn;
      Rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    Rst = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
